// File: rtl/fp_mul_pkg.sv
// Shared FP32 types and constants for the multiplier front end.
package fp_mul_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   typedef enum logic [1:0] {
      FP_NORM,
      FP_ZERO,
      FP_INF,
      FP_NAN
   } fp_class_t;

   localparam int          FP_BIAS     = 127;
   localparam int          EXP_MAX     = 254;
   localparam logic [31:0] QNAN        = 32'h7FC0_0000;
   // All-ones exponent shared by inf and NaN encodings.
   localparam logic [7:0]  EXP_SPECIAL = QNAN[30:23];

   // Biased exponent sum as a 10-bit two's-complement value (range -bias..510-bias).
   function automatic logic [9:0] exp_sum(input logic [7:0] ea, input logic [7:0] eb, input int bias);
      return {2'b00, ea} + {2'b00, eb} - 10'(bias);
   endfunction

endpackage

// File: rtl/fp_mul_operand_prep_classify.sv
// Combinational FP32 operand classifier: class, sign and mantissa with hidden bit.
module fp32_classify
   import fp_mul_pkg::*;
(
   input  fp32_t        op,
   output fp_class_t    cls,
   output logic         neg,
   output logic [23:0]  mant
);

   always_comb begin
      cls  = FP_NORM;
      mant = {1'b1, op.frac};
      neg  = op.sign;
      // Denormals are flushed to zero along with true zeros.
      if (op.exp == 8'd0) begin
         cls  = FP_ZERO;
         mant = '0;
      end else if (op.exp == EXP_SPECIAL) begin
         cls  = (op.frac == 23'd0) ? FP_INF : FP_NAN;
         mant = '0;
      end
   end

endmodule

// File: rtl/fp_mul_operand_prep.sv
// FP32 multiplier front end: 2-stage elastic pipe (decode, combine) with full backpressure.
module fp_mul_operand_prep
   import fp_mul_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int BIAS  = FP_BIAS
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       op_a,
   input  logic [31:0]       op_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [23:0]       shifted_val,
   output logic [23:0]       nonshifted_val,
   output logic [7:0]        exponent_temp,
   output logic              sign,
   output logic              flag_zero,
   output logic              flag_inf,
   output logic              flag_nan,
   output logic              flag_ovf,
   output logic              flag_unf,
   output logic [TAG_W-1:0]  out_tag
);

   logic              s1_valid_q, s1_valid_d;
   fp32_t             s1_a_q, s1_a_d;
   fp32_t             s1_b_q, s1_b_d;
   logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

   logic              s2_valid_q, s2_valid_d;
   logic [23:0]       s2_mant_a_q, s2_mant_a_d;
   logic [23:0]       s2_mant_b_q, s2_mant_b_d;
   logic [7:0]        s2_exp_q, s2_exp_d;
   logic              s2_sign_q, s2_sign_d;
   logic              s2_zero_q, s2_zero_d;
   logic              s2_inf_q, s2_inf_d;
   logic              s2_nan_q, s2_nan_d;
   logic              s2_ovf_q, s2_ovf_d;
   logic              s2_unf_q, s2_unf_d;
   logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

   logic              s1_load, s2_load;
   fp_class_t         cls_a, cls_b;
   logic              neg_a, neg_b;
   logic [23:0]       mant_a, mant_b;
   logic [9:0]        sum;
   logic              nan_c, inf_c, zero_c, ovf_c, unf_c;

   fp32_classify u_cls_a (.op(s1_a_q), .cls(cls_a), .neg(neg_a), .mant(mant_a));
   fp32_classify u_cls_b (.op(s1_b_q), .cls(cls_b), .neg(neg_b), .mant(mant_b));

   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;

   // Flag priority nan > inf > zero > ovf > unf keeps results one-hot.
   always_comb begin
      sum    = exp_sum(s1_a_q.exp, s1_b_q.exp, BIAS);
      nan_c  = (cls_a == FP_NAN) || (cls_b == FP_NAN)
            || ((cls_a == FP_INF) && (cls_b == FP_ZERO))
            || ((cls_a == FP_ZERO) && (cls_b == FP_INF));
      inf_c  = ((cls_a == FP_INF) || (cls_b == FP_INF)) && !nan_c;
      zero_c = ((cls_a == FP_ZERO) || (cls_b == FP_ZERO)) && !nan_c && !inf_c;
      ovf_c  = !nan_c && !inf_c && !zero_c && ($signed(sum) > EXP_MAX);
      unf_c  = !nan_c && !inf_c && !zero_c && ($signed(sum) < 1);
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_tag_d   = s1_tag_q;
      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d   = op_a;
            s1_b_d   = op_b;
            s1_tag_d = in_tag;
         end
      end
   end

   // Stage-2 data only moves on a real transfer so outputs hold while stalled.
   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_mant_a_d = s2_mant_a_q;
      s2_mant_b_d = s2_mant_b_q;
      s2_exp_d    = s2_exp_q;
      s2_sign_d   = s2_sign_q;
      s2_zero_d   = s2_zero_q;
      s2_inf_d    = s2_inf_q;
      s2_nan_d    = s2_nan_q;
      s2_ovf_d    = s2_ovf_q;
      s2_unf_d    = s2_unf_q;
      s2_tag_d    = s2_tag_q;
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_mant_a_d = mant_a;
            s2_mant_b_d = mant_b;
            s2_exp_d    = sum[7:0];
            s2_sign_d   = neg_a ^ neg_b;
            s2_zero_d   = zero_c;
            s2_inf_d    = inf_c;
            s2_nan_d    = nan_c;
            s2_ovf_d    = ovf_c;
            s2_unf_d    = unf_c;
            s2_tag_d    = s1_tag_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_mant_a_q <= '0;
         s2_mant_b_q <= '0;
         s2_exp_q    <= '0;
         s2_sign_q   <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_inf_q    <= 1'b0;
         s2_nan_q    <= 1'b0;
         s2_ovf_q    <= 1'b0;
         s2_unf_q    <= 1'b0;
         s2_tag_q    <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         s2_mant_a_q <= s2_mant_a_d;
         s2_mant_b_q <= s2_mant_b_d;
         s2_exp_q    <= s2_exp_d;
         s2_sign_q   <= s2_sign_d;
         s2_zero_q   <= s2_zero_d;
         s2_inf_q    <= s2_inf_d;
         s2_nan_q    <= s2_nan_d;
         s2_ovf_q    <= s2_ovf_d;
         s2_unf_q    <= s2_unf_d;
         s2_tag_q    <= s2_tag_d;
      end
   end

   assign out_valid      = s2_valid_q;
   assign shifted_val    = s2_mant_a_q;
   assign nonshifted_val = s2_mant_b_q;
   assign exponent_temp  = s2_exp_q;
   assign sign           = s2_sign_q;
   assign flag_zero      = s2_zero_q;
   assign flag_inf       = s2_inf_q;
   assign flag_nan       = s2_nan_q;
   assign flag_ovf       = s2_ovf_q;
   assign flag_unf       = s2_unf_q;
   assign out_tag        = s2_tag_q;

endmodule
